// File: rtl/pipe_reg_skid_pkg.sv
// Shared pcpu types for the inter-stage pipeline register.
package pcpu;
  localparam logic [31:0] NOP_INST_DEF = 32'h00000013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        lvalid;
  } PipeLane_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } PipeRegState_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } Debug_t;
endpackage

// File: rtl/pipe_reg_skid_entry.sv
// One storage entry: LANES instruction slots plus sideband, with load,
// kill-on-load (slots become NOPs, PCs/sideband kept) and synchronous clear.
module pipe_reg_entry
  import pcpu::*;
#(
  parameter int          LANES    = 1,
  parameter int          SIDE_W   = 8,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic                   clk_PR,
  input  logic                   clear,
  input  logic                   load,
  input  logic                   kill,
  input  logic [LANES-1:0][31:0] d_pc,
  input  logic [LANES-1:0][31:0] d_inst,
  input  logic [LANES-1:0]       d_lmask,
  input  logic [SIDE_W-1:0]      d_side,
  output logic [LANES-1:0][31:0] q_pc,
  output logic [LANES-1:0][31:0] q_inst,
  output logic [LANES-1:0]       q_lmask,
  output logic [SIDE_W-1:0]      q_side
);
  PipeLane_t [LANES-1:0] lane_q;
  logic [SIDE_W-1:0]     side_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    always_ff @(posedge clk_PR) begin
      if (clear) begin
        lane_q[g] <= '{pc: 32'h0, inst: NOP_INST, lvalid: 1'b0};
      end else if (load) begin
        lane_q[g].pc     <= d_pc[g];
        lane_q[g].inst   <= kill ? NOP_INST : d_inst[g];
        lane_q[g].lvalid <= d_lmask[g] & ~kill;
      end
    end
    assign q_pc[g]    = lane_q[g].pc;
    assign q_inst[g]  = lane_q[g].inst;
    assign q_lmask[g] = lane_q[g].lvalid;
  end

  always_ff @(posedge clk_PR) begin
    if (clear)     side_q <= '0;
    else if (load) side_q <= d_side;
  end

  assign q_side = side_q;
endmodule

// File: rtl/pipe_reg_skid.sv
// Valid/ready pipeline register with a two-entry skid buffer, flush and bubble
// injection. Optional PIPE_REG_DEBUG_EN adds debug_out_PR/stall_cnt_PR/flush_cnt_PR.
module pipe_reg_skid
  import pcpu::*;
#(
  parameter int          LANES    = 1,
  parameter int          SIDE_W   = 8,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic                   clk_PR,
  input  logic                   rstn_PR,
  input  logic                   in_valid_PR,
  output logic                   in_ready_PR,
  input  logic [LANES-1:0][31:0] in_pc_PR,
  input  logic [LANES-1:0][31:0] in_inst_PR,
  input  logic [LANES-1:0]       in_lmask_PR,
  input  logic [SIDE_W-1:0]      in_side_PR,
  input  logic                   kill_in_PR,
  input  logic                   flush_PR,
  output logic                   out_valid_PR,
  input  logic                   out_ready_PR,
  output logic [LANES-1:0][31:0] out_pc_PR,
  output logic [LANES-1:0][31:0] out_inst_PR,
  output logic [LANES-1:0]       out_lmask_PR,
  output logic [SIDE_W-1:0]      out_side_PR
`ifdef PIPE_REG_DEBUG_EN
  ,
  output Debug_t                 debug_out_PR,
  output logic [31:0]            stall_cnt_PR,
  output logic [31:0]            flush_cnt_PR
`endif
);
  PipeRegState_t state_q;
  logic          out_valid_q;
  logic          acc, fire, live;
  logic          main_load, main_from_skid, main_kill, skid_load;

  logic [LANES-1:0][31:0] main_pc, main_inst, skid_pc, skid_inst;
  logic [LANES-1:0][31:0] main_d_pc, main_d_inst;
  logic [LANES-1:0]       main_lmask, skid_lmask, main_d_lmask;
  logic [SIDE_W-1:0]      main_side, skid_side, main_d_side;

  // in_ready depends only on registered state and reset, never on out_ready.
  assign in_ready_PR = rstn_PR & (state_q != FULL);
  assign acc         = in_valid_PR & in_ready_PR;
  assign fire        = out_valid_q & out_ready_PR;
  assign live        = rstn_PR & ~flush_PR;

  always_ff @(posedge clk_PR) begin
    if (!rstn_PR) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
    end else if (flush_PR) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: if (acc) begin
          state_q     <= ONE;
          out_valid_q <= 1'b1;
        end
        ONE: if (acc && !fire) begin
          state_q <= FULL;
        end else if (!acc && fire) begin
          state_q     <= EMPTY;
          out_valid_q <= 1'b0;
        end
        FULL: if (fire) state_q <= ONE;
        default: begin
          state_q     <= EMPTY;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign main_from_skid = (state_q == FULL);
  assign main_load = live & (((state_q == EMPTY) & acc) |
                             ((state_q == ONE) & acc & fire) |
                             ((state_q == FULL) & fire));
  assign skid_load = live & (state_q == ONE) & acc & ~fire;
  // Skid contents were already killed on their way in.
  assign main_kill    = ~main_from_skid & kill_in_PR;
  assign main_d_pc    = main_from_skid ? skid_pc    : in_pc_PR;
  assign main_d_inst  = main_from_skid ? skid_inst  : in_inst_PR;
  assign main_d_lmask = main_from_skid ? skid_lmask : in_lmask_PR;
  assign main_d_side  = main_from_skid ? skid_side  : in_side_PR;

  pipe_reg_entry #(.LANES(LANES), .SIDE_W(SIDE_W), .NOP_INST(NOP_INST)) u_main (
    .clk_PR (clk_PR),
    .clear  (~rstn_PR),
    .load   (main_load),
    .kill   (main_kill),
    .d_pc   (main_d_pc),
    .d_inst (main_d_inst),
    .d_lmask(main_d_lmask),
    .d_side (main_d_side),
    .q_pc   (main_pc),
    .q_inst (main_inst),
    .q_lmask(main_lmask),
    .q_side (main_side)
  );

  pipe_reg_entry #(.LANES(LANES), .SIDE_W(SIDE_W), .NOP_INST(NOP_INST)) u_skid (
    .clk_PR (clk_PR),
    .clear  (~rstn_PR | flush_PR),
    .load   (skid_load),
    .kill   (kill_in_PR),
    .d_pc   (in_pc_PR),
    .d_inst (in_inst_PR),
    .d_lmask(in_lmask_PR),
    .d_side (in_side_PR),
    .q_pc   (skid_pc),
    .q_inst (skid_inst),
    .q_lmask(skid_lmask),
    .q_side (skid_side)
  );

  // PC and sideband keep the last main contents while the head is invalid.
  assign out_valid_PR = out_valid_q;
  assign out_pc_PR    = main_pc;
  assign out_side_PR  = main_side;
  assign out_lmask_PR = out_valid_q ? main_lmask : '0;
  for (genvar g = 0; g < LANES; g++) begin : g_out
    assign out_inst_PR[g] = out_valid_q ? main_inst[g] : NOP_INST;
  end

`ifdef PIPE_REG_DEBUG_EN
  always_ff @(posedge clk_PR) begin
    if (!rstn_PR) begin
      debug_out_PR <= '0;
      stall_cnt_PR <= '0;
      flush_cnt_PR <= '0;
    end else begin
      if (acc)                        debug_out_PR <= '{pc: in_pc_PR[0], inst: in_inst_PR[0]};
      if (out_valid_q && !out_ready_PR) stall_cnt_PR <= stall_cnt_PR + 32'd1;
      if (flush_PR)                   flush_cnt_PR <= flush_cnt_PR + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_reg_skid.sv
// Bench for pipe_reg_skid (LANES=2): directed steps then random traffic,
// checked every cycle against a queue-based model of the beat stream.
module tb_pipe_reg_skid;
  import pcpu::*;
  localparam int L  = 2;
  localparam int SW = 8;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rstn, in_valid, in_ready, kill, flush, out_valid, out_ready;
  logic [L-1:0][31:0] in_pc, in_inst, out_pc, out_inst;
  logic [L-1:0]       in_lmask, out_lmask;
  logic [SW-1:0]      in_side, out_side;
`ifdef PIPE_REG_DEBUG_EN
  Debug_t      dbg;
  logic [31:0] stall_cnt, flush_cnt;
  logic [31:0] m_stall, m_flush, m_dbg_pc, m_dbg_inst;
`endif

  pipe_reg_skid #(.LANES(L), .SIDE_W(SW), .NOP_INST(NOP)) dut (
    .clk_PR(clk), .rstn_PR(rstn),
    .in_valid_PR(in_valid), .in_ready_PR(in_ready),
    .in_pc_PR(in_pc), .in_inst_PR(in_inst), .in_lmask_PR(in_lmask), .in_side_PR(in_side),
    .kill_in_PR(kill), .flush_PR(flush),
    .out_valid_PR(out_valid), .out_ready_PR(out_ready),
    .out_pc_PR(out_pc), .out_inst_PR(out_inst), .out_lmask_PR(out_lmask), .out_side_PR(out_side)
`ifdef PIPE_REG_DEBUG_EN
    , .debug_out_PR(dbg), .stall_cnt_PR(stall_cnt), .flush_cnt_PR(flush_cnt)
`endif
  );

  typedef struct packed {
    logic [L-1:0][31:0] pc;
    logic [L-1:0][31:0] inst;
    logic [L-1:0]       lmask;
    logic [SW-1:0]      side;
  } beat_t;

  beat_t              q[$];
  logic [L-1:0][31:0] last_pc;
  logic [SW-1:0]      last_side;
  int passed = 0, failed = 0, total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("in_ready", 64'(in_ready), 64'(rstn && q.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_pc", out_pc, q[0].pc);
      chk("out_inst", out_inst, q[0].inst);
      chk("out_lmask", 64'(out_lmask), 64'(q[0].lmask));
      chk("out_side", 64'(out_side), 64'(q[0].side));
    end else begin
      chk("idle_pc", out_pc, last_pc);
      chk("idle_inst", out_inst, {NOP, NOP});
      chk("idle_lmask", 64'(out_lmask), 64'(0));
      chk("idle_side", 64'(out_side), 64'(last_side));
    end
`ifdef PIPE_REG_DEBUG_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));
    chk("debug_out", {dbg.pc, dbg.inst}, {m_dbg_pc, m_dbg_inst});
`endif
  endtask

  // Drive one cycle of inputs, advance the model on the edge, check on the negedge.
  task automatic step(input logic rs, input logic v, input logic [31:0] pc0,
                      input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] lm,
                      input logic [7:0] sd, input logic ordy, input logic k, input logic fl);
    bit acc, fire;
    beat_t b;
    rstn = rs; in_valid = v; in_pc = {pc0 + 32'd4, pc0}; in_inst = {i1, i0};
    in_lmask = lm; in_side = sd; out_ready = ordy; kill = k; flush = fl;
    acc  = rs && v && q.size() < 2;
    fire = rs && q.size() > 0 && ordy;
    b.pc = in_pc; b.side = sd;
    b.inst  = k ? {NOP, NOP} : in_inst;
    b.lmask = k ? 2'b00 : lm;
    @(posedge clk);
`ifdef PIPE_REG_DEBUG_EN
    if (!rs) begin
      m_stall = 0; m_flush = 0; m_dbg_pc = 0; m_dbg_inst = 0;
    end else begin
      if (q.size() > 0 && !ordy) m_stall++;
      if (fl) m_flush++;
      if (acc) begin m_dbg_pc = pc0; m_dbg_inst = i0; end
    end
`endif
    if (!rs) begin
      q.delete(); last_pc = '0; last_side = '0;
    end else if (fl) begin
      q.delete();
    end else begin
      if (fire) void'(q.pop_front());
      if (acc) q.push_back(b);
    end
    if (q.size() > 0) begin last_pc = q[0].pc; last_side = q[0].side; end
    @(negedge clk);
    check_all();
  endtask

  task automatic beat(input logic v, input logic [31:0] pc0, input logic ordy,
                      input logic k, input logic fl);
    step(1'b1, v, pc0, pc0 ^ 32'hA5000000, pc0 ^ 32'h5A000000, 2'b11, pc0[9:2], ordy, k, fl);
  endtask

  initial begin
    rstn = 0; in_valid = 0; in_pc = '0; in_inst = '0; in_lmask = '0; in_side = '0;
    kill = 0; flush = 0; out_ready = 0; last_pc = '0; last_side = '0;
`ifdef PIPE_REG_DEBUG_EN
    m_stall = 0; m_flush = 0; m_dbg_pc = 0; m_dbg_inst = 0;
`endif
    @(negedge clk);
    // Reset held two cycles with a valid beat presented: nothing accepted.
    step(1'b0, 1'b1, 32'h40, 32'h1, 32'h2, 2'b11, 8'h1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h40, 32'h1, 32'h2, 2'b11, 8'h1, 1'b1, 1'b0, 1'b0);
    rstn = 1'b1; in_valid = 1'b0; #1;
    chk("ready_after_reset", 64'(in_ready), 64'(1));

    // Full-rate stream.
    for (int i = 0; i < 4; i++) beat(1'b1, 32'h100 + 32'(8 * i), 1'b1, 1'b0, 1'b0);
    beat(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Backpressure: second beat lands in skid, third held upstream.
    beat(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    beat(1'b1, 32'h104, 1'b0, 1'b0, 1'b0);
    beat(1'b1, 32'h108, 1'b0, 1'b0, 1'b0);
    beat(1'b1, 32'h108, 1'b1, 1'b0, 1'b0);
    beat(1'b1, 32'h108, 1'b1, 1'b0, 1'b0);
    beat(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    beat(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Flush while FULL, then flush while accepting in ONE.
    beat(1'b1, 32'h1F0, 1'b0, 1'b0, 1'b0);
    beat(1'b1, 32'h1F8, 1'b0, 1'b0, 1'b0);
    beat(1'b1, 32'h200, 1'b0, 1'b0, 1'b1);
    chk("flush_valid", 64'(out_valid), 64'(0));
    beat(1'b1, 32'h210, 1'b0, 1'b0, 1'b0);
    beat(1'b1, 32'h220, 1'b1, 1'b0, 1'b1);
    beat(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Killed beat still flows as a bubble.
    step(1'b1, 1'b1, 32'h300, 32'h00500093, 32'h00500093, 2'b11, 8'h33, 1'b0, 1'b1, 1'b0);
    chk("kill_inst", 64'(out_inst[0]), 64'(NOP));
    chk("kill_pc", 64'(out_pc[0]), 64'(32'h300));
    beat(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(63) != 0), ($urandom_range(3) != 0), $urandom & 32'hFFFFFFFC,
           $urandom, $urandom, 2'($urandom), 8'($urandom), ($urandom_range(2) != 0),
           ($urandom_range(7) == 0), ($urandom_range(15) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
